// File: rtl/bdd_traverse_engine.sv
// bdd_traverse_engine: loadable decision-graph classifier, walks one node per two cycles from ROOT to a leaf
module bdd_traverse_engine #(
  parameter int ATTR_W    = 10,
  parameter int N_ATTR    = 3,
  parameter int ADDR_W    = 5,
  parameter int DEPTH     = 32,
  parameter int CLASS_W   = 8,
  parameter int ROOT      = 0,
  parameter int MAX_STEPS = DEPTH,
  localparam int SEL_W    = N_ATTR > 1 ? $clog2(N_ATTR) : 1,
  localparam int NODE_W   = 1 + SEL_W + ATTR_W + 2 * ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [NODE_W-1:0]        wr_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_ATTR*ATTR_W-1:0] in_attr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CLASS_W-1:0]       out_class,
  output logic [ADDR_W:0]          out_steps,
  output logic                     out_err
);
  typedef enum logic [1:0] {IDLE, FETCH, EVAL, DONE} state_t;
  state_t                         state_q, state_d;
  logic [NODE_W-1:0]              mem [DEPTH];
  logic [NODE_W-1:0]              rd_q;
  logic [N_ATTR-1:0][ATTR_W-1:0]  attr_q, attr_d;
  logic [ADDR_W-1:0]              addr_q, addr_d, nxt;
  logic [ADDR_W:0]                steps_q, steps_d, steps_inc;
  logic [CLASS_W-1:0]             class_q, class_d;
  logic                           err_q, err_d, leaf, sel_ok, wr_ok;
  logic [SEL_W-1:0]               sel;
  logic [ATTR_W-1:0]              thr, a;

  assign wr_ok     = rst && wr_en && state_q == IDLE && int'(wr_addr) < DEPTH;
  assign in_ready  = rst && state_q == IDLE && !wr_en;
  assign out_valid = state_q == DONE;
  assign out_class = class_q;
  assign out_steps = steps_q;
  assign out_err   = err_q;
  assign leaf      = rd_q[NODE_W-1];
  assign sel       = rd_q[NODE_W-2 -: SEL_W];
  assign thr       = rd_q[2*ADDR_W +: ATTR_W];
  assign sel_ok    = int'(sel) < N_ATTR;
  assign nxt       = a < thr ? rd_q[ADDR_W +: ADDR_W] : rd_q[0 +: ADDR_W];
  assign steps_inc = steps_q + 1'b1;

  // Node store: writes land only while idle; the read is registered so FETCH's address is decoded in EVAL
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
    rd_q <= int'(addr_q) < DEPTH ? mem[addr_q] : '0;
  end

  // Pick the attribute addressed by the node's selector (zero when the selector is out of range)
  always_comb begin
    a = '0;
    for (int i = 0; i < N_ATTR; i++) a = int'(sel) == i ? attr_q[i] : a;
  end

  // Traversal state and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      attr_q  <= '0;
      addr_q  <= '0;
      steps_q <= '0;
      class_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      attr_q  <= attr_d;
      addr_q  <= addr_d;
      steps_q <= steps_d;
      class_q <= class_d;
      err_q   <= err_d;
    end
  end

  // Next-state: accept a job, alternate fetch/evaluate until a leaf, bad selector or step guard, then hand off
  always_comb begin
    state_d = state_q;
    attr_d  = attr_q;
    addr_d  = addr_q;
    steps_d = steps_q;
    class_d = class_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (in_valid && in_ready) begin
        attr_d  = in_attr;
        addr_d  = ADDR_W'(ROOT);
        steps_d = '0;
        state_d = FETCH;
      end
      FETCH: state_d = EVAL;
      EVAL: if (leaf) begin
        class_d = rd_q[CLASS_W-1:0];
        err_d   = 1'b0;
        state_d = DONE;
      end else if (!sel_ok) begin
        class_d = '0;
        err_d   = 1'b1;
        state_d = DONE;
      end else begin
        addr_d  = nxt;
        steps_d = steps_inc;
        err_d   = steps_inc == (ADDR_W+1)'(MAX_STEPS);
        class_d = steps_inc == (ADDR_W+1)'(MAX_STEPS) ? '0 : class_q;
        state_d = steps_inc == (ADDR_W+1)'(MAX_STEPS) ? DONE : FETCH;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_bdd_traverse_engine.sv
// tb_bdd_traverse_engine: directed and randomized checks of the classifier against a graph-walk reference model
module tb_bdd_traverse_engine;
  logic        clk, rst, wr_en, in_valid, out_ready, in_ready, out_valid, out_err;
  logic [4:0]  wr_addr;
  logic [22:0] wr_data;
  logic [29:0] in_attr;
  logic [7:0]  out_class;
  logic [5:0]  out_steps;
  logic [22:0] mm [32];
  int          tests, fails;

  bdd_traverse_engine dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_attr(in_attr),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .out_steps(out_steps), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [22:0] node(int sel, int thr, int lo, int hi);
    return {1'b0, 2'(sel), 10'(thr), 5'(lo), 5'(hi)};
  endfunction

  function automatic logic [22:0] leaf_node(int cls);
    return {1'b1, 14'd0, 8'(cls)};
  endfunction

  // Walk the stored graph: v counts nodes fetched, steps counts internal nodes evaluated
  function automatic void model(input logic [29:0] attr, output int cls, output int steps, output int err, output int v);
    int addr, sel, thr;
    logic [22:0] w;
    addr = 0; steps = 0; v = 0; err = 0; cls = 0;
    for (int k = 0; k < 100; k++) begin
      w = mm[addr];
      v++;
      sel = int'(w[21:20]);
      thr = int'(w[19:10]);
      if (w[22]) begin cls = int'(w[7:0]); return; end
      if (sel >= 3) begin err = 1; return; end
      addr = int'(attr[sel*10 +: 10]) < thr ? int'(w[9:5]) : int'(w[4:0]);
      steps++;
      if (steps == 32) begin err = 1; return; end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input int addr, input logic [22:0] w);
    wr_en = 1'b1; wr_addr = 5'(addr); wr_data = w; mm[addr] = w;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic run_job(input logic [29:0] attr, input int hold, input bit poke, input string tag);
    int cls, st, err, v, n;
    model(attr, cls, st, err, v);
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk({tag, ".in_ready"}, 32'(in_ready), 1);
    in_valid = 1'b1; in_attr = attr;
    @(posedge clk); #1;
    in_valid = 1'b0; in_attr = 30'($urandom);
    n = 1;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    chk({tag, ".latency"}, 32'(n), 32'(2 * v + 1));
    chk({tag, ".class"}, 32'(out_class), 32'(cls));
    chk({tag, ".steps"}, 32'(out_steps), 32'(st));
    chk({tag, ".err"}, 32'(out_err), 32'(err));
    for (int k = 0; k < hold; k++) begin
      if (poke && k == 3) begin wr_en = 1'b1; wr_addr = 5'd1; wr_data = leaf_node(99); end
      @(posedge clk); #1;
      wr_en = 1'b0;
    end
    if (hold > 0) begin
      chk({tag, ".hold_valid"}, 32'(out_valid), 1);
      chk({tag, ".hold_class"}, 32'(out_class), 32'(cls));
      chk({tag, ".hold_steps"}, 32'(out_steps), 32'(st));
      chk({tag, ".hold_err"}, 32'(out_err), 32'(err));
      chk({tag, ".hold_in_ready"}, 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".valid_drop"}, 32'(out_valid), 0);
    chk({tag, ".back_idle"}, 32'(in_ready), 1);
  endtask

  initial begin
    int r;
    tests = 0; fails = 0;
    rst = 1'b0; wr_en = 1'b1; wr_addr = '0; wr_data = '0;
    in_valid = 1'b0; in_attr = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_ready", 32'(in_ready), 0);
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.out_class", 32'(out_class), 0);
    chk("rst.out_steps", 32'(out_steps), 0);
    chk("rst.out_err", 32'(out_err), 0);
    wr_en = 1'b0; rst = 1'b1;
    @(posedge clk); #1;

    wr(0, node(0, 20, 1, 2));
    wr(1, leaf_node(10));
    run_job({10'd49, 10'd30, 10'd14}, 0, 0, "t1");

    wr(2, leaf_node(7));
    run_job({10'd49, 10'd30, 10'd20}, 0, 0, "t2");

    wr(0, node(0, 0, 0, 0));
    run_job(30'($urandom), 0, 0, "t3");

    wr(0, node(3, 0, 1, 2));
    run_job(30'($urandom), 0, 0, "t4");

    wr(0, node(0, 20, 1, 2));
    run_job({10'd49, 10'd30, 10'd14}, 10, 1, "t5");
    run_job({10'd49, 10'd30, 10'd14}, 0, 0, "t5.readback");

    in_valid = 1'b1; in_attr = {10'd49, 10'd30, 10'd14};
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("t6.out_valid", 32'(out_valid), 0);
    chk("t6.in_ready", 32'(in_ready), 0);
    chk("t6.out_class", 32'(out_class), 0);
    chk("t6.out_steps", 32'(out_steps), 0);
    chk("t6.out_err", 32'(out_err), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("t6.no_output", 32'(out_valid), 0);
    run_job({10'd49, 10'd30, 10'd14}, 0, 0, "t6.after");

    for (int i = 0; i < 32; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 3) wr(i, leaf_node(int'($urandom_range(0, 255))));
      else if (r == 9) wr(i, node(3, int'($urandom_range(0, 1023)), 0, 0));
      else wr(i, node(int'($urandom_range(0, 2)), int'($urandom_range(0, 1023)),
                      int'($urandom_range(0, 31)), int'($urandom_range(0, 31))));
    end
    for (int j = 0; j < 25; j++) run_job(30'($urandom), int'($urandom_range(0, 3)), 0, "rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
